// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default layer geometry, the sequencer
// state encoding and the saturating add used by every accumulator.
package cnn_pkg;

    localparam int DATA_WIDTH = 24;
    localparam int NUM_CH     = 6;
    localparam int OUT_PIXELS = 100;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Add in DATA_WIDTH+1 bits, then clamp to the signed DATA_WIDTH range.
    function automatic logic signed [DATA_WIDTH-1:0] sat_add(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
            return s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return s[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational W-bit signed saturating adder. At the shared layer width it
// reuses the package function so every layer clamps identically.
module sat_adder #(
    parameter int W = 24
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum
);

    generate
        if (W == cnn_pkg::DATA_WIDTH) begin : g_pkg
            assign sum = cnn_pkg::sat_add(a, b);
        end else begin : g_generic
            logic signed [W:0] s;
            assign s   = {a[W-1], a} + {b[W-1], b};
            assign sum = (s[W] != s[W-1])
                       ? (s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                       : s[W-1:0];
        end
    endgenerate

endmodule

// File: rtl/featuremap_channel_sequencer.sv
// Steps one conv engine through NUM_CH input channels, accumulating the
// per-channel partial sums pixel by pixel and emitting the saturated,
// bias-added feature map while the last channel streams in.
module featuremap_channel_sequencer #(
    parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter int NUM_CH     = cnn_pkg::NUM_CH,
    parameter int OUT_PIXELS = cnn_pkg::OUT_PIXELS,
    parameter logic signed [DATA_WIDTH-1:0] BIAS = '0,
    parameter int CH_W       = 3,
    parameter int PIX_W      = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         valid_in,
    output logic        [CH_W-1:0]       ch_sel,
    output logic                         ch_start,
    output logic                         busy,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         valid_out,
    output logic                         done
);

    import cnn_pkg::*;

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(OUT_PIXELS - 1);

    seq_state_t state, state_n;
    logic [CH_W-1:0]  ch_sel_n;
    logic [PIX_W-1:0] pix_cnt, pix_n;
    logic ch_start_n, busy_n, valid_out_n, done_n;
    logic signed [DATA_WIDTH-1:0] data_out_n;

    // Per-pixel running sums; channel 0 overwrites, so no reset is needed.
    logic signed [DATA_WIDTH-1:0] acc_buf [OUT_PIXELS];
    logic signed [DATA_WIDTH-1:0] buf_rd, acc_sum, out_sum;

    logic accept, first_ch, last_ch, last_pix;

    assign accept   = (state == RUN) && valid_in;
    assign first_ch = (ch_sel == '0);
    assign last_ch  = (ch_sel == LAST_CH);
    assign last_pix = (pix_cnt == LAST_PIX);
    assign buf_rd   = acc_buf[pix_cnt];

    // Running sum plus this channel's partial sum.
    sat_adder #(.W(DATA_WIDTH)) u_acc_add (
        .a   (buf_rd),
        .b   (data_in),
        .sum (acc_sum)
    );

    // Bias is folded in only on the output path of the last channel.
    sat_adder #(.W(DATA_WIDTH)) u_bias_add (
        .a   (acc_sum),
        .b   (BIAS),
        .sum (out_sum)
    );

    // Control and output registers; reset abandons any pass in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch_sel    <= '0;
            pix_cnt   <= '0;
            ch_start  <= 1'b0;
            busy      <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            ch_sel    <= ch_sel_n;
            pix_cnt   <= pix_n;
            ch_start  <= ch_start_n;
            busy      <= busy_n;
            data_out  <= data_out_n;
            valid_out <= valid_out_n;
            done      <= done_n;
        end
    end

    // Accumulation buffer write for every channel except the last.
    always_ff @(posedge clk) begin
        if (!rst && accept && !last_ch) begin
            acc_buf[pix_cnt] <= first_ch ? data_in : acc_sum;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_n     = state;
        ch_sel_n    = ch_sel;
        pix_n       = pix_cnt;
        ch_start_n  = 1'b0;
        busy_n      = busy;
        data_out_n  = data_out;
        valid_out_n = 1'b0;
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                // A start coinciding with the done pulse is deliberately dropped.
                if (start && !done) begin
                    state_n    = RUN;
                    ch_sel_n   = '0;
                    pix_n      = '0;
                    busy_n     = 1'b1;
                    ch_start_n = 1'b1;
                end
            end
            RUN: begin
                if (valid_in) begin
                    pix_n = last_pix ? '0 : pix_cnt + 1'b1;
                    if (last_ch) begin
                        valid_out_n = 1'b1;
                        data_out_n  = out_sum;
                    end
                    if (last_pix) begin
                        if (last_ch) begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            ch_sel_n   = ch_sel + 1'b1;
                            ch_start_n = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_featuremap_channel_sequencer.sv
// Bench for featuremap_channel_sequencer: two instances (BIAS=0 and BIAS=5)
// share one stimulus stream; expected pixels are queued as the last channel
// is driven and popped when valid_out appears.
module tb_featuremap_channel_sequencer;

    localparam int DW   = 24;
    localparam int NCH  = 6;
    localparam int NPIX = 100;
    localparam int CW   = 3;
    localparam int PW   = 7;

    logic clk = 1'b0;
    logic rst, start, valid_in;
    logic signed [DW-1:0] data_in;

    logic [CW-1:0] ch_sel_a, ch_sel_b;
    logic ch_start_a, ch_start_b, busy_a, busy_b;
    logic valid_out_a, valid_out_b, done_a, done_b;
    logic signed [DW-1:0] data_out_a, data_out_b;

    featuremap_channel_sequencer #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .OUT_PIXELS(NPIX),
        .BIAS(24'sd0), .CH_W(CW), .PIX_W(PW)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .valid_in(valid_in), .ch_sel(ch_sel_a), .ch_start(ch_start_a),
        .busy(busy_a), .data_out(data_out_a), .valid_out(valid_out_a),
        .done(done_a)
    );

    featuremap_channel_sequencer #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .OUT_PIXELS(NPIX),
        .BIAS(24'sd5), .CH_W(CW), .PIX_W(PW)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .valid_in(valid_in), .ch_sel(ch_sel_b), .ch_start(ch_start_b),
        .busy(busy_b), .data_out(data_out_b), .valid_out(valid_out_b),
        .done(done_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cs_cnt = 0;
    int done_cnt = 0;

    logic signed [DW-1:0] q_a[$];
    logic signed [DW-1:0] q_b[$];
    logic signed [DW-1:0] mbuf [NPIX];

    function automatic logic signed [DW-1:0] add_sat(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
        longint v;
        v = longint'(a) + longint'(b);
        if (v > 64'sd8388607)  return 24'sh7FFFFF;
        if (v < -64'sd8388608) return 24'sh800000;
        return DW'(v);
    endfunction

    function automatic logic signed [DW-1:0] gen(input int mode, input int c, input int p);
        case (mode)
            0:       return 24'sd1;
            1:       return DW'(c * 100 + p);
            2:       return 24'sh3FFFFF;
            3:       return 24'shC00000;
            default: return 24'sd2;
        endcase
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        logic signed [DW-1:0] exp_v;
        if (ch_start_a) cs_cnt++;
        if (done_a) done_cnt++;
        if (valid_out_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL out_a_unexpected got=%0d want=no_output", data_out_a);
            end else begin
                exp_v = q_a.pop_front();
                if (data_out_a !== exp_v) begin
                    errors++;
                    $display("FAIL out_a_data got=%0d want=%0d", data_out_a, exp_v);
                end
            end
        end
        if (valid_out_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL out_b_unexpected got=%0d want=no_output", data_out_b);
            end else begin
                exp_v = q_b.pop_front();
                if (data_out_b !== exp_v) begin
                    errors++;
                    $display("FAIL out_b_data got=%0d want=%0d", data_out_b, exp_v);
                end
            end
        end
        if (done_a || done_b) begin
            checks++;
            if (!(done_a && valid_out_a && done_b && valid_out_b)) begin
                errors++;
                $display("FAIL done_with_valid got=%b%b%b%b want=1111",
                         done_a, valid_out_a, done_b, valid_out_b);
            end
        end
    end

    task automatic run_pass(input int mode, input int max_gap, input bit noise,
                            input int abort_ch, input int abort_pix);
        logic signed [DW-1:0] d, acc;
        int g;
        cs_cnt   = 0;
        done_cnt = 0;
        if (noise) begin
            repeat (3) begin
                valid_in = 1'b1; data_in = 24'sh123456;
                @(posedge clk); #1;
                valid_in = 1'b0;
                @(posedge clk); #1;
            end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got=%b%b want=11", busy_a, busy_b);
        end
        for (int c = 0; c < NCH; c++) begin
            for (int p = 0; p < NPIX; p++) begin
                d = gen(mode, c, p);
                if (c == abort_ch && p == abort_pix) begin
                    rst = 1'b1; valid_in = 1'b1; data_in = d;
                    @(posedge clk); #1;
                    rst = 1'b0; valid_in = 1'b0;
                    checks++;
                    if (ch_sel_a !== '0 || ch_start_a !== 1'b0 || busy_a !== 1'b0 ||
                        data_out_a !== '0 || valid_out_a !== 1'b0 || done_a !== 1'b0 ||
                        ch_sel_b !== '0 || busy_b !== 1'b0 || valid_out_b !== 1'b0) begin
                        errors++;
                        $display("FAIL abort_reset got=%0d%b%b%0d%b%b want=000000",
                                 ch_sel_a, ch_start_a, busy_a, data_out_a, valid_out_a, done_a);
                    end
                    return;
                end
                checks++;
                if (ch_sel_a !== CW'(c) || ch_sel_b !== CW'(c)) begin
                    errors++;
                    $display("FAIL ch_sel got=%0d/%0d want=%0d", ch_sel_a, ch_sel_b, c);
                end
                valid_in = 1'b1; data_in = d;
                if (c == 0) mbuf[p] = d;
                else if (c < NCH - 1) mbuf[p] = add_sat(mbuf[p], d);
                else begin
                    acc = add_sat(mbuf[p], d);
                    q_a.push_back(add_sat(acc, 24'sd0));
                    q_b.push_back(add_sat(acc, 24'sd5));
                end
                @(posedge clk); #1;
                valid_in = 1'b0;
                if (!(c == NCH - 1 && p == NPIX - 1) && max_gap > 0) begin
                    g = $urandom_range(max_gap, 1);
                    repeat (g) begin
                        if (noise) start = 1'b1;
                        data_in = 24'sh7ABCDE;
                        @(posedge clk); #1;
                        start = 1'b0;
                    end
                end
            end
        end
        checks++;
        if (done_a !== 1'b1 || done_b !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle got=done%b%b busy%b%b want=done11 busy00",
                     done_a, done_b, busy_a, busy_b);
        end
        if (noise) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || ch_start_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done got=busy%b%b ch_start%b want=busy00 ch_start0",
                     busy_a, busy_b, ch_start_a);
        end
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL beats_missing got=%0d/%0d want=0", q_a.size(), q_b.size());
        end
        checks++;
        if (cs_cnt != NCH) begin
            errors++;
            $display("FAIL ch_start_count got=%0d want=%0d", cs_cnt, NCH);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL done_count got=%0d want=1", done_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; valid_in = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ch_sel_a !== '0 || ch_start_a !== 1'b0 || busy_a !== 1'b0 ||
            data_out_a !== '0 || valid_out_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a got=%0d%b%b%0d%b%b want=000000",
                     ch_sel_a, ch_start_a, busy_a, data_out_a, valid_out_a, done_a);
        end
        checks++;
        if (ch_sel_b !== '0 || ch_start_b !== 1'b0 || busy_b !== 1'b0 ||
            data_out_b !== '0 || valid_out_b !== 1'b0 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b got=%0d%b%b%0d%b%b want=000000",
                     ch_sel_b, ch_start_b, busy_b, data_out_b, valid_out_b, done_b);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_sum();
        run_pass(0, 0, 1'b0, -1, -1);
    endtask

    task automatic test_bias_ramp();
        run_pass(1, 0, 1'b0, -1, -1);
    endtask

    task automatic test_pos_saturation();
        run_pass(2, 0, 1'b0, -1, -1);
    endtask

    task automatic test_neg_saturation();
        run_pass(3, 0, 1'b0, -1, -1);
    endtask

    task automatic test_gaps_and_ignored_starts();
        run_pass(1, 3, 1'b1, -1, -1);
    endtask

    task automatic test_reset_mid_run();
        cs_cnt = 0;
        run_pass(1, 0, 1'b0, 3, 40);
        @(posedge clk); #1;
        checks++;
        if (done_cnt != 0 || q_a.size() != 0) begin
            errors++;
            $display("FAIL abort_no_done got=%0d/%0d want=0/0", done_cnt, q_a.size());
        end
        run_pass(4, 0, 1'b0, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_pass(0, 0, 1'b0, -1, -1);
        run_pass(4, 0, 1'b0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_bias_ramp();
        test_pos_saturation();
        test_neg_saturation();
        test_gaps_and_ignored_starts();
        test_reset_mid_run();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
